// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: datapath width, register index width,
// ALU operation encodings and operand source-select codes.
package riscv_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  localparam logic [1:0] A_SEL_RS1  = 2'd0;
  localparam logic [1:0] A_SEL_PC   = 2'd1;
  localparam logic [1:0] A_SEL_ZERO = 2'd2;

  localparam logic [1:0] B_SEL_RS2  = 2'd0;
  localparam logic [1:0] B_SEL_IMM  = 2'd1;
  localparam logic [1:0] B_SEL_FOUR = 2'd2;

endpackage

// File: rtl/alu_operand_stage_fwd_mux.sv
// Resolves one register operand against the EX, MEM and WB forwarding
// sources (youngest first); x0 always reads as zero.
module fwd_mux #(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic [riscv_pkg::REG_IDX_W-1:0] i_idx,
  input  logic [XLEN-1:0]                 i_rf_data,
  input  logic                            i_ex_en,
  input  logic [riscv_pkg::REG_IDX_W-1:0] i_ex_idx,
  input  logic [XLEN-1:0]                 i_ex_data,
  input  logic                            i_mem_we,
  input  logic [riscv_pkg::REG_IDX_W-1:0] i_mem_idx,
  input  logic [XLEN-1:0]                 i_mem_data,
  input  logic                            i_wb_we,
  input  logic [riscv_pkg::REG_IDX_W-1:0] i_wb_idx,
  input  logic [XLEN-1:0]                 i_wb_data,
  output logic [XLEN-1:0]                 o_data
);

  always_comb begin
    o_data = i_rf_data;
    if (i_idx == '0)
      o_data = '0;
    else if (i_ex_en && (i_ex_idx == i_idx))
      o_data = i_ex_data;
    else if (i_mem_we && (i_mem_idx == i_idx))
      o_data = i_mem_data;
    else if (i_wb_we && (i_wb_idx == i_idx))
      o_data = i_wb_data;
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register: forwards and selects ALU operands, stalls one cycle
// on load-use, and obeys downstream back-pressure and flush.
module alu_operand_stage #(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1_idx,
  input  logic [4:0]      id_rs2_idx,
  input  logic [4:0]      id_rd_idx,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic [1:0]      id_a_sel,
  input  logic [1:0]      id_b_sel,
  input  logic [3:0]      id_alu_op,
  input  logic            id_rd_we,
  input  logic            id_is_load,
  input  logic [XLEN-1:0] ex_result,
  input  logic            mem_rd_we,
  input  logic [4:0]      mem_rd_idx,
  input  logic [XLEN-1:0] mem_rd_data,
  input  logic            wb_rd_we,
  input  logic [4:0]      wb_rd_idx,
  input  logic [XLEN-1:0] wb_rd_data,
  input  logic            flush,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [XLEN-1:0] op_a,
  output logic [XLEN-1:0] op_b,
  output logic [3:0]      ex_alu_op,
  output logic [4:0]      ex_rd_idx,
  output logic            ex_rd_we,
  output logic            ex_is_load
);
  import riscv_pkg::*;

  logic            r_ex_valid;
  logic [XLEN-1:0] r_op_a;
  logic [XLEN-1:0] r_op_b;
  logic [3:0]      r_ex_alu_op;
  logic [4:0]      r_ex_rd_idx;
  logic            r_ex_rd_we;
  logic            r_ex_is_load;

  logic            w_advance;
  logic            w_load_use;
  logic            w_ex_fwd_en;
  logic [XLEN-1:0] w_rs1_fwd;
  logic [XLEN-1:0] w_rs2_fwd;
  logic [XLEN-1:0] w_op_a;
  logic [XLEN-1:0] w_op_b;

  assign w_advance = !r_ex_valid || ex_ready;

  // A load in EX has no result yet, so a consumer must wait a cycle and pick it up from MEM.
  assign w_load_use = r_ex_valid && r_ex_is_load && (r_ex_rd_idx != '0) &&
                      ((id_use_rs1 && (id_rs1_idx == r_ex_rd_idx)) ||
                       (id_use_rs2 && (id_rs2_idx == r_ex_rd_idx)));

  assign id_ready    = w_advance && !w_load_use && !flush;
  assign w_ex_fwd_en = r_ex_valid && r_ex_rd_we && !r_ex_is_load;

  fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
    .i_idx      (id_rs1_idx),
    .i_rf_data  (id_rs1_data),
    .i_ex_en    (w_ex_fwd_en),
    .i_ex_idx   (r_ex_rd_idx),
    .i_ex_data  (ex_result),
    .i_mem_we   (mem_rd_we),
    .i_mem_idx  (mem_rd_idx),
    .i_mem_data (mem_rd_data),
    .i_wb_we    (wb_rd_we),
    .i_wb_idx   (wb_rd_idx),
    .i_wb_data  (wb_rd_data),
    .o_data     (w_rs1_fwd)
  );

  fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
    .i_idx      (id_rs2_idx),
    .i_rf_data  (id_rs2_data),
    .i_ex_en    (w_ex_fwd_en),
    .i_ex_idx   (r_ex_rd_idx),
    .i_ex_data  (ex_result),
    .i_mem_we   (mem_rd_we),
    .i_mem_idx  (mem_rd_idx),
    .i_mem_data (mem_rd_data),
    .i_wb_we    (wb_rd_we),
    .i_wb_idx   (wb_rd_idx),
    .i_wb_data  (wb_rd_data),
    .o_data     (w_rs2_fwd)
  );

  always_comb begin
    w_op_a = '0;
    case (id_a_sel)
      A_SEL_RS1: w_op_a = w_rs1_fwd;
      A_SEL_PC:  w_op_a = id_pc;
      default:   w_op_a = '0;
    endcase
  end

  always_comb begin
    w_op_b = id_imm;
    case (id_b_sel)
      B_SEL_RS2:  w_op_b = w_rs2_fwd;
      B_SEL_FOUR: w_op_b = XLEN'(4);
      default:    w_op_b = id_imm;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid   <= 1'b0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_ex_alu_op  <= ALU_ADD;
      r_ex_rd_idx  <= '0;
      r_ex_rd_we   <= 1'b0;
      r_ex_is_load <= 1'b0;
    end else if (flush) begin
      r_ex_valid <= 1'b0;
    end else if (w_advance && id_valid && !w_load_use) begin
      r_ex_valid   <= 1'b1;
      r_op_a       <= w_op_a;
      r_op_b       <= w_op_b;
      r_ex_alu_op  <= id_alu_op;
      r_ex_rd_idx  <= id_rd_idx;
      r_ex_rd_we   <= id_rd_we;
      r_ex_is_load <= id_is_load;
    end else if (w_advance) begin
      r_ex_valid <= 1'b0;
    end
  end

  assign ex_valid   = r_ex_valid;
  assign op_a       = r_op_a;
  assign op_b       = r_op_b;
  assign ex_alu_op  = r_ex_alu_op;
  assign ex_rd_idx  = r_ex_rd_idx;
  assign ex_rd_we   = r_ex_rd_we;
  assign ex_is_load = r_ex_is_load;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage; a behavioural ADD ALU closes the EX forwarding loop.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1_idx, id_rs2_idx, id_rd_idx;
  logic        id_use_rs1, id_use_rs2;
  logic [1:0]  id_a_sel, id_b_sel;
  logic [3:0]  id_alu_op;
  logic        id_rd_we, id_is_load;
  logic [31:0] ex_result;
  logic        mem_rd_we;
  logic [4:0]  mem_rd_idx;
  logic [31:0] mem_rd_data;
  logic        wb_rd_we;
  logic [4:0]  wb_rd_idx;
  logic [31:0] wb_rd_data;
  logic        flush;
  logic        ex_ready;
  logic        ex_valid;
  logic [31:0] op_a, op_b;
  logic [3:0]  ex_alu_op;
  logic [4:0]  ex_rd_idx;
  logic        ex_rd_we, ex_is_load;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign ex_result = op_a + op_b;

  alu_operand_stage #(.XLEN(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_pc       (id_pc),
    .id_rs1_data (id_rs1_data),
    .id_rs2_data (id_rs2_data),
    .id_imm      (id_imm),
    .id_rs1_idx  (id_rs1_idx),
    .id_rs2_idx  (id_rs2_idx),
    .id_rd_idx   (id_rd_idx),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .id_a_sel    (id_a_sel),
    .id_b_sel    (id_b_sel),
    .id_alu_op   (id_alu_op),
    .id_rd_we    (id_rd_we),
    .id_is_load  (id_is_load),
    .ex_result   (ex_result),
    .mem_rd_we   (mem_rd_we),
    .mem_rd_idx  (mem_rd_idx),
    .mem_rd_data (mem_rd_data),
    .wb_rd_we    (wb_rd_we),
    .wb_rd_idx   (wb_rd_idx),
    .wb_rd_data  (wb_rd_data),
    .flush       (flush),
    .ex_ready    (ex_ready),
    .ex_valid    (ex_valid),
    .op_a        (op_a),
    .op_b        (op_b),
    .ex_alu_op   (ex_alu_op),
    .ex_rd_idx   (ex_rd_idx),
    .ex_rd_we    (ex_rd_we),
    .ex_is_load  (ex_is_load)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_rs1_idx = 0; id_rs2_idx = 0; id_rd_idx = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_a_sel = 0; id_b_sel = 0; id_alu_op = 0; id_rd_we = 0; id_is_load = 0;
    mem_rd_we = 0; mem_rd_idx = 0; mem_rd_data = 0;
    wb_rd_we = 0; wb_rd_idx = 0; wb_rd_data = 0;
    flush = 0; ex_ready = 1;
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [31:0] rs1d,
                       input logic [4:0] rs2, input logic [31:0] rs2d,
                       input logic [1:0] asel, input logic [1:0] bsel,
                       input logic [31:0] imm, input logic [4:0] rd,
                       input logic ld);
    id_valid = 1; id_rs1_idx = rs1; id_rs1_data = rs1d; id_rs2_idx = rs2; id_rs2_data = rs2d;
    id_use_rs1 = (asel == 2'd0); id_use_rs2 = (bsel == 2'd0);
    id_a_sel = asel; id_b_sel = bsel; id_imm = imm; id_rd_idx = rd;
    id_rd_we = (rd != 0) || !ld; id_is_load = ld; id_alu_op = 4'd0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    #1;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid: got %b expected 0", ex_valid); end
    checks++; if (op_a !== 32'h0 || op_b !== 32'h0) begin errors++; $display("FAIL reset_ops: got %h/%h expected 0/0", op_a, op_b); end
    checks++; if ({ex_alu_op, ex_rd_idx, ex_rd_we, ex_is_load} !== 11'h0) begin errors++; $display("FAIL reset_ctrl: got %h/%h/%b/%b expected all 0", ex_alu_op, ex_rd_idx, ex_rd_we, ex_is_load); end
    #10 rst_n = 1;
    tick();
    $display("reset: ex_valid=%b op_a=%h op_b=%h", ex_valid, op_a, op_b);
  endtask

  task automatic test_ex_forward();
    drive(5'd0, 32'h0, 5'd0, 32'h0, 2'd2, 2'd1, 32'd7, 5'd5, 1'b0);
    #1;
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL exfwd_ready: got %b expected 1", id_ready); end
    tick();
    drive(5'd5, 32'hDEAD, 5'd1, 32'd3, 2'd0, 2'd0, 32'd0, 5'd6, 1'b0);
    checks++; if (ex_valid !== 1'b1 || ex_result !== 32'd7) begin errors++; $display("FAIL exfwd_first: got valid=%b result=%h expected 1/7", ex_valid, ex_result); end
    tick();
    id_valid = 0;
    checks++; if (op_a !== 32'd7 || op_b !== 32'd3) begin errors++; $display("FAIL exfwd_ops: got %h/%h expected 7/3", op_a, op_b); end
    checks++; if (ex_result !== 32'd10 || ex_rd_idx !== 5'd6) begin errors++; $display("FAIL exfwd_result: got %h rd=%0d expected 10 rd=6", ex_result, ex_rd_idx); end
    $display("ex_forward: op_a=%h op_b=%h result=%h", op_a, op_b, ex_result);
    tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL exfwd_drain: got %b expected 0", ex_valid); end
  endtask

  task automatic test_load_use();
    drive(5'd2, 32'h100, 5'd0, 32'h0, 2'd0, 2'd1, 32'd0, 5'd5, 1'b1);
    tick();
    drive(5'd5, 32'hBAD0, 5'd5, 32'hBAD1, 2'd0, 2'd0, 32'd0, 5'd6, 1'b0);
    #1;
    checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL lu_stall: got id_ready=%b expected 0", id_ready); end
    tick();
    mem_rd_we = 1; mem_rd_idx = 5'd5; mem_rd_data = 32'h1234;
    #1;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble: got ex_valid=%b expected 0", ex_valid); end
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL lu_release: got id_ready=%b expected 1", id_ready); end
    tick();
    id_valid = 0; mem_rd_we = 0;
    checks++; if (ex_valid !== 1'b1 || op_a !== 32'h1234 || op_b !== 32'h1234) begin errors++; $display("FAIL lu_capture: got valid=%b %h/%h expected 1 1234/1234", ex_valid, op_a, op_b); end
    $display("load_use: op_a=%h op_b=%h", op_a, op_b);
    tick();
  endtask

  task automatic test_priority();
    drive(5'd7, 32'h99, 5'd7, 32'h98, 2'd0, 2'd0, 32'd0, 5'd8, 1'b0);
    mem_rd_we = 1; mem_rd_idx = 5'd7; mem_rd_data = 32'hA;
    wb_rd_we = 1; wb_rd_idx = 5'd7; wb_rd_data = 32'hB;
    tick();
    checks++; if (op_a !== 32'hA || op_b !== 32'hA) begin errors++; $display("FAIL prio_mem_over_wb: got %h/%h expected A/A", op_a, op_b); end
    $display("priority mem/wb: op_a=%h op_b=%h", op_a, op_b);
    mem_rd_idx = 5'd9;
    drive(5'd7, 32'h99, 5'd9, 32'h98, 2'd0, 2'd0, 32'd0, 5'd8, 1'b0);
    tick();
    checks++; if (op_a !== 32'hB || op_b !== 32'hA) begin errors++; $display("FAIL prio_wb: got %h/%h expected B/A", op_a, op_b); end
    drive(5'd1, 32'h5, 5'd0, 32'h0, 2'd2, 2'd1, 32'hFF, 5'd0, 1'b0);
    id_rd_we = 1;
    mem_rd_idx = 5'd0; mem_rd_data = 32'hFF; wb_rd_idx = 5'd0; wb_rd_data = 32'hFF;
    tick();
    drive(5'd0, 32'hFF, 5'd0, 32'hFF, 2'd0, 2'd0, 32'd0, 5'd3, 1'b0);
    tick();
    id_valid = 0; mem_rd_we = 0; wb_rd_we = 0;
    checks++; if (op_a !== 32'h0 || op_b !== 32'h0) begin errors++; $display("FAIL x0_zero: got %h/%h expected 0/0", op_a, op_b); end
    $display("x0: op_a=%h op_b=%h", op_a, op_b);
    tick();
  endtask

  task automatic test_back_to_back();
    drive(5'd0, 32'h0, 5'd0, 32'h0, 2'd2, 2'd1, 32'h11, 5'd10, 1'b0);
    tick();
    drive(5'd0, 32'h0, 5'd0, 32'h0, 2'd2, 2'd1, 32'h22, 5'd11, 1'b0);
    ex_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %b expected 0", i, id_ready); end
      checks++; if (ex_valid !== 1'b1 || op_b !== 32'h11 || ex_rd_idx !== 5'd10) begin errors++; $display("FAIL bp_hold[%0d]: got valid=%b op_b=%h rd=%0d expected 1/11/10", i, ex_valid, op_b, ex_rd_idx); end
      tick();
    end
    ex_ready = 1;
    #1;
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got %b expected 1", id_ready); end
    tick();
    id_valid = 0;
    checks++; if (ex_valid !== 1'b1 || op_b !== 32'h22 || ex_rd_idx !== 5'd11) begin errors++; $display("FAIL bp_next: got valid=%b op_b=%h rd=%0d expected 1/22/11", ex_valid, op_b, ex_rd_idx); end
    $display("back_to_back: op_b=%h rd=%0d", op_b, ex_rd_idx);
    tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got %b expected 0", ex_valid); end
  endtask

  task automatic test_flush();
    drive(5'd0, 32'h0, 5'd0, 32'h0, 2'd2, 2'd1, 32'h33, 5'd12, 1'b0);
    tick();
    flush = 1;
    #1;
    checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b expected 0", id_ready); end
    tick();
    flush = 0; id_valid = 0;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_kill: got %b expected 0", ex_valid); end
    $display("flush: ex_valid=%b", ex_valid);
    drive(5'd0, 32'h0, 5'd0, 32'h0, 2'd1, 2'd2, 32'h0, 5'd13, 1'b1);
    id_pc = 32'h40; id_alu_op = 4'd3;
    tick();
    id_valid = 0;
    checks++; if (ex_valid !== 1'b1 || ex_is_load !== 1'b1 || ex_alu_op !== 4'd3) begin errors++; $display("FAIL prereset_load: got valid=%b ld=%b op=%0d expected 1/1/3", ex_valid, ex_is_load, ex_alu_op); end
    #2 rst_n = 0;
    #1;
    checks++; if (ex_valid !== 1'b0 || op_a !== 32'h0 || op_b !== 32'h0) begin errors++; $display("FAIL async_reset_data: got valid=%b %h/%h expected 0 0/0", ex_valid, op_a, op_b); end
    checks++; if ({ex_alu_op, ex_rd_idx, ex_rd_we, ex_is_load} !== 11'h0) begin errors++; $display("FAIL async_reset_ctrl: got %h/%h/%b/%b expected all 0", ex_alu_op, ex_rd_idx, ex_rd_we, ex_is_load); end
    $display("async reset: ex_valid=%b op_a=%h", ex_valid, op_a);
    #2 rst_n = 1;
    tick();
  endtask

  task automatic test_src_select();
    drive(5'd3, 32'h77, 5'd4, 32'h66, 2'd1, 2'd2, 32'h5, 5'd14, 1'b0);
    id_pc = 32'h100;
    tick();
    checks++; if (op_a !== 32'h100 || op_b !== 32'h4) begin errors++; $display("FAIL sel_pc_four: got %h/%h expected 100/4", op_a, op_b); end
    $display("src pc/4: op_a=%h op_b=%h", op_a, op_b);
    drive(5'd3, 32'h77, 5'd4, 32'h66, 2'd2, 2'd1, 32'hFFFFF800, 5'd15, 1'b0);
    tick();
    checks++; if (op_a !== 32'h0 || op_b !== 32'hFFFFF800) begin errors++; $display("FAIL sel_zero_imm: got %h/%h expected 0/FFFFF800", op_a, op_b); end
    drive(5'd3, 32'h77, 5'd4, 32'h66, 2'd3, 2'd3, 32'h123, 5'd16, 1'b0);
    tick();
    id_valid = 0;
    checks++; if (op_a !== 32'h0 || op_b !== 32'h123) begin errors++; $display("FAIL sel_reserved: got %h/%h expected 0/123", op_a, op_b); end
    $display("src zero/imm: op_a=%h op_b=%h", op_a, op_b);
    tick();
  endtask

  initial begin
    test_reset();
    test_ex_forward();
    test_load_use();
    test_priority();
    test_back_to_back();
    test_flush();
    test_src_select();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
